// File: rtl/shift_pkg.sv
// ============================================================================
// Module      : shift_pkg
// Description : Shared types and helpers for the multicycle ALU shift units.
//               Holds the controller state encoding and the stage-count
//               helpers used to size shifter parameters and counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    // Controller states, shared by the multicycle shift units.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

    // Number of barrel stages needed to cover every shift amount of an
    // n-bit operand.
    function automatic int shift_stages(input int n);
        return $clog2(n);
    endfunction

    // Width of a counter that has to reach the value `stages` itself
    // (the trailing pass-through slot after the last real stage).
    function automatic int stage_cnt_width(input int stages);
        return $clog2(stages + 1);
    endfunction

    localparam int c_DEFAULT_N      = 32;
    localparam int c_DEFAULT_STAGES = shift_stages(c_DEFAULT_N);

endpackage

`default_nettype wire

// File: rtl/shift_left_stage.sv
// ============================================================================
// Module      : shift_left_stage
// Description : One logical-left barrel stage selected by index. Stage i
//               shifts by 2**i when enabled and flags any 1 bit pushed past
//               the MSB. Disabled, it passes data through with no loss.
// Ports       : i_data  [N-1:0]  value entering the stage
//               i_stage [SW-1:0] stage index (shift distance 2**i_stage)
//               i_en             apply the shift this cycle
//               o_data  [N-1:0]  shifted (or passed-through) value
//               o_lost           1 if a 1 bit left the MSB end
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_left_stage #(
    parameter int N  = 32,
    parameter int SW = 3
) (
    input  logic [N-1:0]  i_data,
    input  logic [SW-1:0] i_stage,
    input  logic          i_en,
    output logic [N-1:0]  o_data,
    output logic          o_lost
);

    logic [N-1:0] w_shifted;
    logic [N-1:0] w_out_mask;

    always_comb begin
        w_shifted  = i_data << (1 << i_stage);
        // Ones in the top 2**i_stage positions: the bits this stage evicts.
        w_out_mask = ~({N{1'b1}} >> (1 << i_stage));
        if (i_en) begin
            o_data = w_shifted;
            o_lost = |(i_data & w_out_mask);
        end else begin
            o_data = i_data;
            o_lost = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_left_logical_multicycle.sv
// ============================================================================
// Module      : shift_left_logical_multicycle
// Description : Iterative logical-left shifter with ready/valid handshakes.
//               One barrel stage is retired per cycle (shamt bit i handled
//               in stage i) through a single stage instance indexed by a
//               counter. A sticky flag reports any 1 bit shifted out of the
//               MSB. Accept at edge k gives o_valid after edge k+STAGES+1.
// Ports       : clk, rst            clock, synchronous active-high reset
//               i_valid / i_ready   operand handshake
//               in [N-1:0]          value to shift
//               shamt [STAGES-1:0]  shift amount
//               o_valid / o_ready   result handshake
//               out [N-1:0]         in << shamt (qualify with o_valid)
//               lost                1 bit shifted past bit N-1
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

import shift_pkg::*;

module shift_left_logical_multicycle #(
    parameter int N      = 32,
    parameter int STAGES = shift_stages(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [N-1:0]      in,
    input  logic [STAGES-1:0] shamt,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [N-1:0]      out,
    output logic              lost
);

    localparam int             c_SW   = stage_cnt_width(STAGES);
    // The counter runs one slot past the last real stage; that slot is a
    // pass-through cycle that fixes the latency at STAGES+1 edges.
    localparam logic [c_SW-1:0] c_LAST = c_SW'(STAGES);

    shift_state_e      r_state;
    shift_state_e      w_state_nxt;
    logic [N-1:0]      r_data;
    logic [STAGES-1:0] r_shamt;
    logic              r_lost;
    logic [c_SW-1:0]   r_stage;

    logic              w_accept;
    logic              w_stage_en;
    logic              w_stage_lost;
    logic [N-1:0]      w_stage_data;
    logic [STAGES:0]   w_shamt_ext;

    // Zero-extended so the pass-through slot reads a 0 enable bit.
    assign w_shamt_ext = {1'b0, r_shamt};
    assign w_stage_en  = (r_state == SHIFT) & w_shamt_ext[r_stage];
    assign w_accept    = i_valid & i_ready;

    shift_left_stage #(
        .N  (N),
        .SW (c_SW)
    ) u_stage (
        .i_data  (r_data),
        .i_stage (r_stage),
        .i_en    (w_stage_en),
        .o_data  (w_stage_data),
        .o_lost  (w_stage_lost)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // i_ready depends combinationally on o_ready in DONE so a new operand
    // can be taken in the same cycle the result is handed off.
    always_comb begin
        w_state_nxt = r_state;
        i_ready     = 1'b0;
        o_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_stage == c_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                i_ready = o_ready;
                if (o_ready) begin
                    w_state_nxt = i_valid ? SHIFT : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_shamt <= '0;
            r_lost  <= 1'b0;
            r_stage <= '0;
        end else if (w_accept) begin
            r_data  <= in;
            r_shamt <= shamt;
            r_lost  <= 1'b0;
            r_stage <= '0;
        end else if (r_state == SHIFT) begin
            r_data  <= w_stage_data;
            r_lost  <= r_lost | w_stage_lost;
            r_stage <= r_stage + c_SW'(1);
        end
    end

    assign out  = r_data;
    assign lost = r_lost;

endmodule

`default_nettype wire
